regfile_sb: RTL and testbench



---
 rtl/regfile_sb_if.sv | 42 ++++
 rtl/regfile_sb.sv | 153 +++++++++++++++
 tb/tb_regfile_sb.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_if
// Description : Bus bundle for regfile_sb. Groups the write-back write port,
//               the two decode read ports, the issue/scoreboard signals and
//               the bulk-clear handshake. "master" drives the pipeline side,
//               "slave" is the register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  // write port
  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;
  // read ports
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  // scoreboard
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_wa;
  logic              busy1;
  logic              busy2;
  // bulk clear
  logic              clr_req;
  logic              clr_busy;

  modport master (
    output we3, wa3, wd3, ra1, ra2, issue_valid, issue_wa, clr_req,
    input  rd1, rd2, busy1, busy2, clr_busy
  );

  modport slave (
    input  we3, wa3, wd3, ra1, ra2, issue_valid, issue_wa, clr_req,
    output rd1, rd2, busy1, busy2, clr_busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Parametrised register file, 1 write / 2 combinational read
//               ports, hardwired zero register, per-register pending-write
//               scoreboard and a sequenced bulk-clear engine (IDLE/CLEAR).
//               Optional macro RF_BYPASS_EN enables write-through forwarding
//               of the write port onto the read data and busy outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  regfile_sb_if.slave bus
);

  localparam int                DEPTH       = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] c_FIRST_IDX = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_LAST_IDX  = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_CLEAR = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  // Entry 0 is reset to zero and never written, so it folds to a constant;
  // reads of address 0 are also gated explicitly below.
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pending_q;

  logic              w_wr_acc;
  logic              w_iss_acc;
  logic              w_clr_step;
  logic [DATA_W-1:0] w_rd1_base;
  logic [DATA_W-1:0] w_rd2_base;
  logic              w_busy1_base;
  logic              w_busy2_base;

  // FSM state and clear index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_ST_IDLE;
      idx_q   <= c_FIRST_IDX;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FSM next state: sweep idx from 1 to DEPTH-1, then return to IDLE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      c_ST_IDLE: begin
        if (bus.clr_req) begin
          state_d = c_ST_CLEAR;
          idx_d   = c_FIRST_IDX;
        end
      end
      c_ST_CLEAR: begin
        if (idx_q == c_LAST_IDX) begin
          state_d = c_ST_IDLE;
          idx_d   = c_FIRST_IDX;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = c_ST_IDLE;
        idx_d   = c_FIRST_IDX;
      end
    endcase
  end

  // FSM outputs: writes and issues are only accepted in IDLE
  always_comb begin
    bus.clr_busy = (state_q == c_ST_CLEAR);
    w_clr_step   = (state_q == c_ST_CLEAR);
    w_wr_acc     = (state_q == c_ST_IDLE) && bus.we3 && (bus.wa3 != '0);
    w_iss_acc    = (state_q == c_ST_IDLE) && bus.issue_valid && (bus.issue_wa != '0);
  end

  // Register storage: clear engine has priority, else the write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (w_clr_step) begin
      regs_q[idx_q] <= '0;
    end else if (w_wr_acc) begin
      regs_q[bus.wa3] <= bus.wd3;
    end
  end

  // Scoreboard: issue is applied after write so a same-edge issue wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else if (w_clr_step) begin
      pending_q[idx_q] <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        pending_q[bus.wa3] <= 1'b0;
      end
      if (w_iss_acc) begin
        pending_q[bus.issue_wa] <= 1'b1;
      end
    end
  end

  // Stored read data and scoreboard lookup, address 0 forced to zero/idle
  always_comb begin
    w_rd1_base   = (bus.ra1 == '0) ? '0 : regs_q[bus.ra1];
    w_rd2_base   = (bus.ra2 == '0) ? '0 : regs_q[bus.ra2];
    w_busy1_base = (bus.ra1 == '0) ? 1'b0 : pending_q[bus.ra1];
    w_busy2_base = (bus.ra2 == '0) ? 1'b0 : pending_q[bus.ra2];
  end

`ifdef RF_BYPASS_EN
  logic w_fwd1;
  logic w_fwd2;
  logic w_iss_hit1;
  logic w_iss_hit2;

  // Write-through forwarding; a same-cycle re-issue keeps the register busy
  always_comb begin
    w_fwd1     = w_wr_acc && (bus.wa3 == bus.ra1);
    w_fwd2     = w_wr_acc && (bus.wa3 == bus.ra2);
    w_iss_hit1 = bus.issue_valid && (bus.issue_wa == bus.ra1);
    w_iss_hit2 = bus.issue_valid && (bus.issue_wa == bus.ra2);
    bus.rd1    = w_fwd1 ? bus.wd3 : w_rd1_base;
    bus.rd2    = w_fwd2 ? bus.wd3 : w_rd2_base;
    bus.busy1  = w_busy1_base && !(w_fwd1 && !w_iss_hit1);
    bus.busy2  = w_busy2_base && !(w_fwd2 && !w_iss_hit2);
  end
`else
  // No forwarding: outputs follow stored state only
  always_comb begin
    bus.rd1   = w_rd1_base;
    bus.rd2   = w_rd2_base;
    bus.busy1 = w_busy1_base;
    bus.busy2 = w_busy2_base;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Directed self-checking bench for regfile_sb. Instantiates an
//               8x8 (DATA_W=8, ADDR_W=3) and a 16x32 (DATA_W=32, ADDR_W=4)
//               copy. Expected same-cycle values follow RF_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

`ifdef RF_BYPASS_EN
  localparam bit c_BYP = 1'b1;
`else
  localparam bit c_BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(8),  .ADDR_W(3)) bus ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(4)) bus_w ();

  regfile_sb #(.DATA_W(8), .ADDR_W(3)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(4)) u_dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w)
  );

  task automatic idle_inputs();
    bus.we3 = 1'b0; bus.wa3 = '0; bus.wd3 = '0; bus.ra1 = '0; bus.ra2 = '0;
    bus.issue_valid = 1'b0; bus.issue_wa = '0; bus.clr_req = 1'b0;
    bus_w.we3 = 1'b0; bus_w.wa3 = '0; bus_w.wd3 = '0; bus_w.ra1 = '0; bus_w.ra2 = '0;
    bus_w.issue_valid = 1'b0; bus_w.issue_wa = '0; bus_w.clr_req = 1'b0;
  endtask

  // One write on the 8-bit DUT; returns at the negedge after the write edge
  task automatic wr8(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.we3 = 1'b1; bus.wa3 = a; bus.wd3 = d;
    @(negedge clk);
    bus.we3 = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      bus.ra1 = 3'(a); bus.ra2 = 3'(7 - a);
      #1;
      n_checks++; if (bus.rd1 !== 8'h00) begin n_errors++; $display("FAIL reset_rd1 a=%0d got=%h exp=00", a, bus.rd1); end
      n_checks++; if (bus.rd2 !== 8'h00) begin n_errors++; $display("FAIL reset_rd2 a=%0d got=%h exp=00", 7 - a, bus.rd2); end
      n_checks++; if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin n_errors++; $display("FAIL reset_busy a=%0d got=%b%b exp=00", a, bus.busy1, bus.busy2); end
    end
    n_checks++; if (bus.clr_busy !== 1'b0) begin n_errors++; $display("FAIL reset_clr_busy got=%b exp=0", bus.clr_busy); end
    n_checks++; if (bus_w.clr_busy !== 1'b0) begin n_errors++; $display("FAIL reset_clr_busy_w got=%b exp=0", bus_w.clr_busy); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    bus.we3 = 1'b1; bus.wa3 = 3'd3; bus.wd3 = 8'h5A; bus.ra1 = 3'd3;
    #1;
    n_checks++; if (bus.rd1 !== (c_BYP ? 8'h5A : 8'h00)) begin n_errors++; $display("FAIL wr_same_cycle got=%h exp=%h", bus.rd1, c_BYP ? 8'h5A : 8'h00); end
    @(negedge clk);
    bus.we3 = 1'b0;
    #1;
    n_checks++; if (bus.rd1 !== 8'h5A) begin n_errors++; $display("FAIL wr_next_cycle got=%h exp=5a", bus.rd1); end
    @(negedge clk);
    bus.we3 = 1'b1; bus.wa3 = 3'd0; bus.wd3 = 8'hFF; bus.ra2 = 3'd0;
    #1;
    n_checks++; if (bus.rd2 !== 8'h00) begin n_errors++; $display("FAIL wr_r0_same got=%h exp=00", bus.rd2); end
    @(negedge clk);
    bus.we3 = 1'b0;
    #1;
    n_checks++; if (bus.rd2 !== 8'h00) begin n_errors++; $display("FAIL wr_r0_after got=%h exp=00", bus.rd2); end
    n_checks++; if (bus.rd1 !== 8'h5A) begin n_errors++; $display("FAIL wr_r3_kept got=%h exp=5a", bus.rd1); end
    wr8(3'd7, 8'hC3);
    bus.ra2 = 3'd7;
    #1;
    n_checks++; if (bus.rd2 !== 8'hC3) begin n_errors++; $display("FAIL wr_r7_port2 got=%h exp=c3", bus.rd2); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    bus.issue_valid = 1'b1; bus.issue_wa = 3'd5; bus.ra1 = 3'd5; bus.ra2 = 3'd2;
    #1;
    n_checks++; if (bus.busy1 !== 1'b0) begin n_errors++; $display("FAIL sb_issue_same got=%b exp=0", bus.busy1); end
    @(negedge clk);
    bus.issue_valid = 1'b0;
    #1;
    n_checks++; if (bus.busy1 !== 1'b1) begin n_errors++; $display("FAIL sb_issue_next got=%b exp=1", bus.busy1); end
    n_checks++; if (bus.busy2 !== 1'b0) begin n_errors++; $display("FAIL sb_other_reg got=%b exp=0", bus.busy2); end
    bus.ra2 = 3'd5;
    #1;
    n_checks++; if (bus.busy2 !== 1'b1) begin n_errors++; $display("FAIL sb_port2 got=%b exp=1", bus.busy2); end
    // write-back of r5 clears its pending bit
    @(negedge clk);
    bus.we3 = 1'b1; bus.wa3 = 3'd5; bus.wd3 = 8'h11;
    #1;
    n_checks++; if (bus.busy1 !== (c_BYP ? 1'b0 : 1'b1)) begin n_errors++; $display("FAIL sb_wb_same_busy got=%b exp=%b", bus.busy1, !c_BYP); end
    n_checks++; if (bus.rd1 !== (c_BYP ? 8'h11 : 8'h00)) begin n_errors++; $display("FAIL sb_wb_same_rd got=%h exp=%h", bus.rd1, c_BYP ? 8'h11 : 8'h00); end
    @(negedge clk);
    bus.we3 = 1'b0;
    #1;
    n_checks++; if (bus.busy1 !== 1'b0) begin n_errors++; $display("FAIL sb_wb_after got=%b exp=0", bus.busy1); end
    n_checks++; if (bus.rd1 !== 8'h11) begin n_errors++; $display("FAIL sb_wb_data got=%h exp=11", bus.rd1); end
    // issue and write on the same edge, register idle beforehand
    @(negedge clk);
    bus.we3 = 1'b1; bus.wa3 = 3'd5; bus.wd3 = 8'h22;
    bus.issue_valid = 1'b1; bus.issue_wa = 3'd5;
    #1;
    n_checks++; if (bus.busy1 !== 1'b0) begin n_errors++; $display("FAIL sb_both_same got=%b exp=0", bus.busy1); end
    @(negedge clk);
    bus.we3 = 1'b0; bus.issue_valid = 1'b0;
    #1;
    n_checks++; if (bus.busy1 !== 1'b1) begin n_errors++; $display("FAIL sb_both_issue_wins got=%b exp=1", bus.busy1); end
    n_checks++; if (bus.rd1 !== 8'h22) begin n_errors++; $display("FAIL sb_both_data got=%h exp=22", bus.rd1); end
    // issue and write again while pending: busy must hold in both builds
    @(negedge clk);
    bus.we3 = 1'b1; bus.wa3 = 3'd5; bus.wd3 = 8'h33;
    bus.issue_valid = 1'b1; bus.issue_wa = 3'd5;
    #1;
    n_checks++; if (bus.busy1 !== 1'b1) begin n_errors++; $display("FAIL sb_reissue_same got=%b exp=1", bus.busy1); end
    n_checks++; if (bus.rd1 !== (c_BYP ? 8'h33 : 8'h22)) begin n_errors++; $display("FAIL sb_reissue_rd got=%h exp=%h", bus.rd1, c_BYP ? 8'h33 : 8'h22); end
    @(negedge clk);
    bus.we3 = 1'b0; bus.issue_valid = 1'b0;
    #1;
    n_checks++; if (bus.busy1 !== 1'b1) begin n_errors++; $display("FAIL sb_reissue_after got=%b exp=1", bus.busy1); end
  endtask

  task automatic test_clear();
    logic [7:0] exp_v;
    for (int i = 1; i < 8; i++) begin
      wr8(3'(i), 8'(i * 16));
    end
    @(negedge clk);
    bus.issue_valid = 1'b1; bus.issue_wa = 3'd6;
    @(negedge clk);
    bus.issue_valid = 1'b0; bus.ra1 = 3'd6;
    #1;
    n_checks++; if (bus.busy1 !== 1'b1) begin n_errors++; $display("FAIL clr_pre_busy got=%b exp=1", bus.busy1); end
    @(negedge clk);
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    for (int k = 1; k < 8; k++) begin
      exp_v = 8'(k * 16);
      bus.ra1 = 3'(k);
      bus.we3 = (k == 4); bus.wa3 = 3'd2; bus.wd3 = 8'hAB;
      bus.issue_valid = (k == 4); bus.issue_wa = 3'd3;
      #1;
      n_checks++; if (bus.clr_busy !== 1'b1) begin n_errors++; $display("FAIL clr_busy_cycle k=%0d got=%b exp=1", k, bus.clr_busy); end
      n_checks++; if (bus.rd1 !== exp_v) begin n_errors++; $display("FAIL clr_before k=%0d got=%h exp=%h", k, bus.rd1, exp_v); end
      @(negedge clk);
      bus.we3 = 1'b0; bus.issue_valid = 1'b0;
      #1;
      n_checks++; if (bus.rd1 !== 8'h00) begin n_errors++; $display("FAIL clr_after k=%0d got=%h exp=00", k, bus.rd1); end
    end
    n_checks++; if (bus.clr_busy !== 1'b0) begin n_errors++; $display("FAIL clr_done got=%b exp=0", bus.clr_busy); end
    for (int a = 0; a < 8; a++) begin
      bus.ra1 = 3'(a); bus.ra2 = 3'(a);
      #1;
      n_checks++; if (bus.rd1 !== 8'h00 || bus.rd2 !== 8'h00) begin n_errors++; $display("FAIL clr_final_rd a=%0d got=%h/%h exp=00", a, bus.rd1, bus.rd2); end
      n_checks++; if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin n_errors++; $display("FAIL clr_final_busy a=%0d got=%b%b exp=00", a, bus.busy1, bus.busy2); end
    end
    wr8(3'd1, 8'h99);
    bus.ra1 = 3'd1;
    #1;
    n_checks++; if (bus.rd1 !== 8'h99) begin n_errors++; $display("FAIL clr_post_write got=%h exp=99", bus.rd1); end
  endtask

  task automatic test_reset_in_clear();
    wr8(3'd4, 8'h44);
    wr8(3'd6, 8'h66);
    @(negedge clk);
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    #1;
    n_checks++; if (bus.clr_busy !== 1'b1) begin n_errors++; $display("FAIL rstclr_started got=%b exp=1", bus.clr_busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.clr_busy !== 1'b0) begin n_errors++; $display("FAIL rstclr_abort got=%b exp=0", bus.clr_busy); end
    for (int a = 1; a < 8; a++) begin
      bus.ra1 = 3'(a);
      #1;
      n_checks++; if (bus.rd1 !== 8'h00) begin n_errors++; $display("FAIL rstclr_regs a=%0d got=%h exp=00", a, bus.rd1); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    wr8(3'd4, 8'h33);
    bus.ra1 = 3'd4;
    #1;
    n_checks++; if (bus.rd1 !== 8'h33) begin n_errors++; $display("FAIL rstclr_write got=%h exp=33", bus.rd1); end
    n_checks++; if (bus.clr_busy !== 1'b0) begin n_errors++; $display("FAIL rstclr_idle got=%b exp=0", bus.clr_busy); end
  endtask

  task automatic test_wide();
    int cnt;
    @(negedge clk);
    bus_w.we3 = 1'b1; bus_w.wa3 = 4'd15; bus_w.wd3 = 32'hDEADBEEF; bus_w.ra1 = 4'd15;
    @(negedge clk);
    bus_w.we3 = 1'b0;
    #1;
    n_checks++; if (bus_w.rd1 !== 32'hDEADBEEF) begin n_errors++; $display("FAIL wide_rd got=%h exp=deadbeef", bus_w.rd1); end
    @(negedge clk);
    bus_w.clr_req = 1'b1;
    @(negedge clk);
    bus_w.clr_req = 1'b0;
    #1;
    cnt = 0;
    while (bus_w.clr_busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    n_checks++; if (cnt != 15) begin n_errors++; $display("FAIL wide_clr_len got=%0d exp=15", cnt); end
    n_checks++; if (bus_w.rd1 !== 32'h0) begin n_errors++; $display("FAIL wide_cleared got=%h exp=00000000", bus_w.rd1); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_clear();
    test_reset_in_clear();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
